qpsk_mapper: RTL
================

# qpsk_mapper

Downstream stage of the packet serializer. Pulls the serialized packet one bit at a time through the serializer's output-request strobe and groups bits into dibits. Maps each dibit (optionally differentially encoded) to a signed QPSK I/Q amplitude pair, then hands the pair to the DAC-side symbol path with a valid/ready handshake. Tracks packet boundaries so the first symbol of every packet is flagged and the differential phase restarts per packet.

## Interface
- SIZE_BIT_PACK, 1976: bits per packet; must be even.
- SIZE_AMPL, 12: width of signed I/Q outputs.
- AMPL, 1448: positive constellation amplitude; must be < 2^(SIZE_AMPL-1).
- DIFF_ENC, 1: 1 = DQPSK (phase accumulated), 0 = plain Gray QPSK.
- SIZE_CNT, $clog2(SIZE_BIT_PACK): width of the bit counter.

- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  run request; low = finish current symbol, then idle.
- o_bit_req  out  1  one-cycle strobe to serializer ready input: advance one bit.
- i_bit  in  1  serial bit from serializer.
- i_bit_valid  in  1  serializer output valid.
- o_i  out  SIZE_AMPL  signed in-phase amplitude.
- o_q  out  SIZE_AMPL  signed quadrature amplitude.
- o_valid  out  1  symbol valid.
- i_ready  in  1  consumer accepts symbol.
- o_frame_start  out  1  qualifies o_valid: symbol carries packet bits 0 and 1.
- o_busy  out  1  FSM not in IDLE.

## Operation
- One clock domain; all state updates on rising i_clk; reset synchronous, active-high.
- Reset: o_bit_req=0, o_valid=0, o_i=0, o_q=0, o_frame_start=0, o_busy=0, bit counter=0, phase=0, FSM=IDLE. Reset mid-symbol discards partial dibit; nothing resumes.
- FSM: IDLE, REQ, WAIT, CAPT, OUT.
  - IDLE: if i_enable go REQ.
  - REQ: o_bit_req=1 (only state with it high); go WAIT.
  - WAIT: go CAPT.
  - CAPT: if i_bit_valid=0, discard, counters unchanged, go REQ (retry). Else store bit (first bit of dibit = b0, second = b1), increment bit counter (wrap SIZE_BIT_PACK-1 -> 0). After b0 go REQ; after b1 compute symbol, go OUT.
  - OUT: o_valid=1, outputs held. On o_valid && i_ready: if i_enable go REQ, else IDLE.
- Frame flag: o_frame_start=1 for the symbol whose b0 was captured at bit counter 0.
- Phase (2 bits, mod 4): DIFF_ENC=1: if frame-start symbol, phase := inc, else phase := phase + inc; inc from (b0,b1): (0,0)=0, (0,1)=1, (1,1)=2, (1,0)=3. Phase-to-output: 0=(+A,+A), 1=(-A,+A), 2=(-A,-A), 3=(+A,-A).
- DIFF_ENC=0: I = b0 ? -AMPL : +AMPL; Q = b1 ? -AMPL : +AMPL; phase register unused (held 0).
- Outputs are sign-correct two's-complement SIZE_AMPL values; no other levels ever driven.
- i_enable deassert never truncates a symbol; dropping it mid-dibit still completes both bits and the handshake.

## Timing
- Per bit: REQ, WAIT, CAPT = 3 cycles; i_bit sampled 2 cycles after o_bit_req high.
- o_valid rises the cycle after second CAPT: 7 cycles from leaving IDLE to first o_valid (IDLE->REQ 1, 6 fetch).
- Minimum symbol period 7 cycles (6 fetch + 1 OUT with i_ready=1).
- No o_bit_req while in OUT; backpressure stalls the serializer with zero bit loss.
- o_valid drops the cycle after handshake; o_i/o_q/o_frame_start keep last value until next symbol.
- o_busy = (state != IDLE), registered with state.

## Test plan
- Reset then idle: i_enable=0 for 20 cycles -> all outputs 0, no o_bit_req.
- DIFF_ENC=0, bits 0,0,1,0,0,1,1,1 -> symbols (+1448,+1448), (-1448,+1448), (+1448,-1448), (-1448,-1448); first has o_frame_start=1, rest 0; o_bit_req 2 cycles before each capture.
- DIFF_ENC=1, from packet start dibits (0,1),(0,1),(1,1) -> phases 1,2,0 -> (-1448,+1448), (-1448,-1448), (+1448,+1448).
- Backpressure: i_ready=0 for 10 cycles with o_valid=1 -> o_i/o_q stable, o_bit_req=0 throughout; i_ready=1 -> one handshake, next o_bit_req the following cycle.
- i_bit_valid=0 at first CAPT -> extra o_bit_req, bit counter still 0, next symbol still o_frame_start=1.
- 988 symbols streamed (1976 bits) -> symbol 989 has o_frame_start=1 and DIFF_ENC phase restarts (dibit (0,0) -> (+1448,+1448)); assert reset mid-dibit -> all outputs 0 next cycle, next symbol flagged frame start.

Source files
------------

// File: rtl/qpsk_mapper.sv
// QPSK / DQPSK symbol mapper: pulls packet bits one at a time from the serializer,
// pairs them into dibits and presents signed I/Q amplitudes on a valid/ready port.
module qpsk_mapper #(
    parameter int SIZE_BIT_PACK = 1976,
    parameter int SIZE_AMPL     = 12,
    parameter int AMPL          = 1448,
    parameter bit DIFF_ENC      = 1'b1,
    parameter int SIZE_CNT      = $clog2(SIZE_BIT_PACK)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    output logic                        o_bit_req,
    input  logic                        i_bit,
    input  logic                        i_bit_valid,
    output logic signed [SIZE_AMPL-1:0] o_i,
    output logic signed [SIZE_AMPL-1:0] o_q,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_frame_start,
    output logic                        o_busy
);

    // Handshake: a symbol transfers on a rising clock edge where o_valid && i_ready;
    // o_valid never drops and o_i/o_q/o_frame_start never change until that transfer.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic [SIZE_AMPL-1:0] L_POS      = SIZE_AMPL'(AMPL);
    localparam logic [SIZE_AMPL-1:0] L_NEG      = SIZE_AMPL'(-AMPL);
    localparam logic [SIZE_CNT-1:0]  L_CNT_LAST = SIZE_CNT'(SIZE_BIT_PACK - 1);

    logic [2:0]           r_state;
    logic [SIZE_CNT-1:0]  r_cnt;
    logic                 r_half;
    logic                 r_b0;
    logic                 r_first;
    logic [1:0]           r_phase;
    logic [SIZE_AMPL-1:0] r_i;
    logic [SIZE_AMPL-1:0] r_q;
    logic                 r_frame_start;

    logic [1:0]           w_inc;
    logic [1:0]           w_phase_next;
    logic                 w_neg_i;
    logic                 w_neg_q;
    logic [SIZE_CNT-1:0]  w_cnt_next;

    // Gray phase increment: (0,0)=0, (0,1)=1, (1,1)=2, (1,0)=3; i_bit is b1 here.
    always_comb begin
        w_inc        = {r_b0, r_b0 ^ i_bit};
        w_phase_next = r_first ? w_inc : (r_phase + w_inc);
        w_neg_i      = r_b0;
        w_neg_q      = i_bit;
        if (DIFF_ENC) begin
            w_neg_i = w_phase_next[1] ^ w_phase_next[0];
            w_neg_q = w_phase_next[1];
        end
        w_cnt_next = (r_cnt == L_CNT_LAST) ? '0 : (r_cnt + 1'b1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_half        <= 1'b0;
            r_b0          <= 1'b0;
            r_first       <= 1'b0;
            r_phase       <= 2'd0;
            r_i           <= '0;
            r_q           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_enable) r_state <= S_REQ;
                S_REQ:  r_state <= S_WAIT;
                S_WAIT: r_state <= S_CAPT;
                S_CAPT: begin
                    if (!i_bit_valid) begin
                        r_state <= S_REQ;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (!r_half) begin
                            r_b0    <= i_bit;
                            r_first <= (r_cnt == '0);
                            r_half  <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_half        <= 1'b0;
                            r_i           <= w_neg_i ? L_NEG : L_POS;
                            r_q           <= w_neg_q ? L_NEG : L_POS;
                            r_frame_start <= r_first;
                            if (DIFF_ENC) r_phase <= w_phase_next;
                            r_state       <= S_OUT;
                        end
                    end
                end
                S_OUT: if (i_ready) r_state <= i_enable ? S_REQ : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bit_req     = (r_state == S_REQ);
    assign o_valid       = (r_state == S_OUT);
    assign o_busy        = (r_state != S_IDLE);
    assign o_i           = r_i;
    assign o_q           = r_q;
    assign o_frame_start = r_frame_start;

endmodule
